// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: sink side of a VGA timing interface. Measures line and
// frame timing from hsync/vsync/de, locks after LOCK_FRAMES consecutive good
// frames and regenerates pixel coordinates plus a frame-buffer write address.
//
// Ports
//   clk_25mhz     in   pixel clock, all inputs synchronous to it
//   rst_n         in   asynchronous active-low reset
//   hsync_in      in   active-low horizontal sync
//   vsync_in      in   active-low vertical sync
//   de_in         in   active-high display enable
//   x_pos         out  pixel column (valid with pixel_valid)
//   y_pos         out  pixel row (valid with pixel_valid)
//   write_addr    out  y_pos*H_ACTIVE + x_pos (valid with pixel_valid)
//   pixel_valid   out  active pixel while locked
//   frame_start   out  pulse with pixel (0,0) of a locked frame
//   locked        out  timing verified
//   timing_err    out  pulse on any violation detected while locked
//   h_total_meas  out  last measured line period in clocks (saturating)
//   v_total_meas  out  last measured lines per frame (saturating)
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [18:0] write_addr,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;
  localparam int unsigned AW = 19;
  localparam int unsigned MW = 11;
  localparam int unsigned GW = 4;
  localparam logic [MW-1:0] M_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] good_cnt, good_nxt;

  logic hs_q, vs_q, de_q;   // stage-1 input registers
  logic hs_d, vs_d, de_d;   // previous stage-1 values for edge detection
  logic hs_edge, vs_edge, de_rise, de_fall;

  logic [MW-1:0] h_cnt, v_cnt, v_cnt_eff, run_cnt, de_lines;
  logic [AW-1:0] row_base, base_nxt;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          frame_pending, frame_bad, pend_eff;
  logic          h_bad, run_bad, x_ovf, y_ovf, vs_bad, frame_good;
  logic          viol, lock_ok;

  // Input capture and edge history
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      de_d <= 1'b0;
    end else begin
      hs_q <= hsync_in;
      vs_q <= vsync_in;
      de_q <= de_in;
      hs_d <= hs_q;
      vs_d <= vs_q;
      de_d <= de_q;
    end
  end

  // Edge detection on the registered inputs
  always_comb begin
    hs_edge = hs_d & ~hs_q;
    vs_edge = vs_d & ~vs_q;
    de_rise = ~de_d & de_q;
    de_fall = de_d & ~de_q;
  end

  // Next coordinates, per-cycle violation terms and frame verdict
  always_comb begin
    v_cnt_eff = v_cnt;
    if (hs_edge && (v_cnt != M_MAX)) v_cnt_eff = v_cnt + MW'(1);

    // A vsync edge coinciding with a line start still makes that line row 0
    pend_eff = frame_pending | vs_edge;

    h_bad   = hs_edge && (h_cnt != MW'(H_TOTAL));
    run_bad = de_fall && (run_cnt != MW'(H_ACTIVE));
    x_ovf   = de_q && !de_rise && (x_pos == XW'(H_ACTIVE - 1));
    y_ovf   = de_rise && !pend_eff && (y_pos == YW'(V_ACTIVE - 1));
    vs_bad  = vs_edge && (v_cnt_eff != MW'(V_TOTAL));

    frame_good = !(frame_bad | h_bad | run_bad | x_ovf | y_ovf) &&
                 (v_cnt_eff == MW'(V_TOTAL)) &&
                 (de_lines == MW'(V_ACTIVE));

    x_nxt    = x_pos;
    y_nxt    = y_pos;
    base_nxt = row_base;
    if (de_rise) begin
      x_nxt = '0;
      if (pend_eff) begin
        y_nxt    = '0;
        base_nxt = '0;
      end else if (!y_ovf) begin
        y_nxt    = y_pos + YW'(1);
        base_nxt = row_base + AW'(H_ACTIVE);
      end
    end else if (de_q && !x_ovf) begin
      x_nxt = x_pos + XW'(1);
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Lock FSM next state; the partial frame before the first vsync is never judged
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    viol      = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (vs_edge) begin
          state_nxt = ST_VERIFY;
          good_nxt  = '0;
        end
      end
      ST_VERIFY: begin
        if (vs_edge) begin
          if (frame_good) begin
            good_nxt = good_cnt + GW'(1);
            if ((good_cnt + GW'(1)) >= GW'(LOCK_FRAMES)) state_nxt = ST_LOCKED;
          end else begin
            good_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        viol = h_bad | run_bad | x_ovf | y_ovf | vs_bad;
        if (viol) begin
          state_nxt = ST_SEARCH;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        good_nxt  = '0;
      end
    endcase
    lock_ok = (state_nxt == ST_LOCKED);
  end

  // Line/frame measurement counters and per-frame sticky state
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      run_cnt       <= '0;
      de_lines      <= '0;
      frame_pending <= 1'b0;
      frame_bad     <= 1'b0;
      h_total_meas  <= '0;
      v_total_meas  <= '0;
    end else begin
      if (hs_edge) begin
        h_total_meas <= h_cnt;
        h_cnt        <= MW'(1);
      end else if (h_cnt != M_MAX) begin
        h_cnt <= h_cnt + MW'(1);
      end

      // A coincident hsync edge is already folded into v_cnt_eff
      if (vs_edge) begin
        v_total_meas <= v_cnt_eff;
        v_cnt        <= '0;
      end else begin
        v_cnt <= v_cnt_eff;
      end

      if (de_rise) begin
        run_cnt <= MW'(1);
      end else if (de_q && (run_cnt != M_MAX)) begin
        run_cnt <= run_cnt + MW'(1);
      end

      if (vs_edge) begin
        de_lines <= de_rise ? MW'(1) : '0;
      end else if (de_rise && (de_lines != M_MAX)) begin
        de_lines <= de_lines + MW'(1);
      end

      frame_pending <= (frame_pending | vs_edge) & ~de_rise;

      if (vs_edge) frame_bad <= 1'b0;
      else         frame_bad <= frame_bad | h_bad | run_bad | x_ovf | y_ovf;
    end
  end

  // Coordinate and address pipeline; row base steps by H_ACTIVE per line
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      x_pos      <= '0;
      y_pos      <= '0;
      row_base   <= '0;
      write_addr <= '0;
    end else if (de_q) begin
      x_pos      <= x_nxt;
      y_pos      <= y_nxt;
      row_base   <= base_nxt;
      write_addr <= base_nxt + AW'(x_nxt);
    end
  end

  // Status outputs; an unlocking cycle already suppresses its own pixel
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      pixel_valid <= de_q & lock_ok;
      frame_start <= de_rise & pend_eff & lock_ok;
      locked      <= lock_ok;
      timing_err  <= viol;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using a reduced 12x7 timing (8x4 active).
module tb_vga_sync_decoder;

  localparam int HA   = 8;
  localparam int VA   = 4;
  localparam int HT   = 12;
  localparam int VT   = 7;
  localparam int HS0  = 9;
  localparam int VS0  = 4;
  localparam int NONE = -1;
  localparam int ALL  = 100000;

  logic        clk_25mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        de_in = 1'b0;
  logic [9:0]  x_pos, y_pos;
  logic [18:0] write_addr;
  logic        pixel_valid, frame_start, locked, timing_err;
  logic [10:0] h_total_meas, v_total_meas;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de_in(de_in), .x_pos(x_pos), .y_pos(y_pos), .write_addr(write_addr),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
    .timing_err(timing_err), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [18:0] addr;
    logic        fs;
    int          cyc;
  } pix_t;

  pix_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pix_cnt, fs_cnt, err_cnt, err_cyc, lock_rise;
  logic [9:0] err_x;
  logic err_pv, err_lk, prev_locked = 1'b0;

  // One pixel clock of stimulus; expected pixels are queued, DUT pixels popped and compared
  task automatic drive(input logic hs, input logic vs, input logic de,
                       input bit push, input int x, input int y);
    pix_t p;
    hsync_in = hs;
    vsync_in = vs;
    de_in    = de;
    if (push && de) begin
      p.x    = 10'(x);
      p.y    = 10'(y);
      p.addr = 19'(y * HA + x);
      p.fs   = (x == 0) && (y == 0);
      p.cyc  = cyc + 2;
      sb.push_back(p);
    end
    @(negedge clk_25mhz);
    cyc++;
    if (pixel_valid) begin
      pix_cnt++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pixel_unexpected: cyc %0d got x=%0d y=%0d addr=%0d, required no pixel",
                 cyc, x_pos, y_pos, write_addr);
      end else begin
        p = sb.pop_front();
        if (x_pos !== p.x || y_pos !== p.y || write_addr !== p.addr ||
            frame_start !== p.fs || cyc != p.cyc) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d addr=%0d fs=%0b cyc=%0d, required x=%0d y=%0d addr=%0d fs=%0b cyc=%0d",
                   x_pos, y_pos, write_addr, frame_start, cyc, p.x, p.y, p.addr, p.fs, p.cyc);
        end
      end
    end
    if (frame_start) fs_cnt++;
    if (timing_err) begin
      err_cnt++;
      err_cyc = cyc;
      err_x   = x_pos;
      err_pv  = pixel_valid;
      err_lk  = locked;
    end
    if (locked && !prev_locked) lock_rise = cyc;
    prev_locked = locked;
  endtask

  // One generated frame with optional faults; stops early after max_cyc clocks
  task automatic send_frame(input int stretch_ln, input int wide_ln, input int drop_ln,
                            input int valid_until, input int max_cyc);
    int  pos;
    int  len;
    logic hs, vs, de;
    pos = 0;
    for (int vc = 0; vc < VT; vc++) begin
      if (vc == drop_ln) continue;
      len = HT + ((vc == stretch_ln) ? 1 : 0);
      for (int hc = 0; hc < len; hc++) begin
        if (pos >= max_cyc) return;
        hs = !(hc >= HS0 && hc < HS0 + 2);
        vs = !((vc == VS0 && hc >= HS0) || (vc == VS0 + 1 && hc < HS0));
        de = (vc < VA) && (hc < HA + ((vc == wide_ln) ? 1 : 0));
        drive(hs, vs, de, pos <= valid_until, hc, vc);
        pos++;
      end
    end
  endtask

  task automatic idle_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_reset(3);
    rst_n = 1'b0;
    n_cmp++;
    if (locked !== 1'b0 || pixel_valid !== 1'b0 || frame_start !== 1'b0 || timing_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got lk=%0b pv=%0b fs=%0b te=%0b, required all 0",
               locked, pixel_valid, frame_start, timing_err);
    end
    n_cmp++;
    if (x_pos !== 10'd0 || y_pos !== 10'd0 || write_addr !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_coords: got x=%0d y=%0d addr=%0d, required 0", x_pos, y_pos, write_addr);
    end
    n_cmp++;
    if (h_total_meas !== 11'd0 || v_total_meas !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_meas: got h=%0d v=%0d, required 0", h_total_meas, v_total_meas);
    end
    rst_n = 1'b1;
  endtask

  // Three frames to lock, then one fully checked locked frame
  task automatic run_lock_sequence(input string tag);
    int s;
    s = cyc;
    lock_rise = -1;
    pix_cnt = 0;
    fs_cnt = 0;
    err_cnt = 0;
    for (int f = 0; f < 3; f++) send_frame(NONE, NONE, NONE, NONE, ALL);
    n_cmp++;
    if (lock_rise != s + 2 * VT * HT + VS0 * HT + HS0 + 2) begin
      n_fail++;
      $display("FAIL %s_lock_cycle: got %0d, required %0d", tag, lock_rise,
               s + 2 * VT * HT + VS0 * HT + HS0 + 2);
    end
    n_cmp++;
    if (pix_cnt != 0 || fs_cnt != 0) begin
      n_fail++;
      $display("FAIL %s_unlocked_pixels: got %0d pixels %0d starts, required 0", tag, pix_cnt, fs_cnt);
    end
    send_frame(NONE, NONE, NONE, ALL, ALL);
    n_cmp++;
    if (pix_cnt != HA * VA || fs_cnt != 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_frame_pixels: got %0d pixels %0d starts %0d pending, required %0d 1 0",
               tag, pix_cnt, fs_cnt, sb.size(), HA * VA);
    end
    n_cmp++;
    if (h_total_meas !== 11'(HT) || v_total_meas !== 11'(VT)) begin
      n_fail++;
      $display("FAIL %s_meas: got h=%0d v=%0d, required h=%0d v=%0d", tag, h_total_meas,
               v_total_meas, HT, VT);
    end
    n_cmp++;
    if (locked !== 1'b1 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL %s_locked_state: got lk=%0b errs=%0d, required lk=1 errs=0", tag, locked, err_cnt);
    end
  endtask

  task automatic test_nominal;
    run_lock_sequence("nominal");
  endtask

  task automatic test_stretch_line;
    int s;
    s = cyc;
    err_cnt = 0;
    // line 1 is 13 clocks; the hsync of line 2 (frame offset 34) measures it
    send_frame(1, NONE, NONE, 2 * HT + 1 + HA - 1, ALL);
    n_cmp++;
    if (err_cnt != 1 || err_cyc != s + 2 * HT + 1 + HS0 + 2 || err_lk !== 1'b0) begin
      n_fail++;
      $display("FAIL stretch_err: got %0d pulses at %0d lk=%0b, required 1 at %0d lk=0",
               err_cnt, err_cyc, err_lk, s + 2 * HT + 1 + HS0 + 2);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL stretch_pending: got %0d queued pixels, required 0", sb.size());
    end
    s = cyc;
    lock_rise = -1;
    send_frame(NONE, NONE, NONE, NONE, ALL);
    send_frame(NONE, NONE, NONE, NONE, ALL);
    n_cmp++;
    if (lock_rise != s + VT * HT + VS0 * HT + HS0 + 2) begin
      n_fail++;
      $display("FAIL stretch_relock: got %0d, required %0d", lock_rise, s + VT * HT + VS0 * HT + HS0 + 2);
    end
    pix_cnt = 0;
    send_frame(NONE, NONE, NONE, ALL, ALL);
    n_cmp++;
    if (pix_cnt != HA * VA || err_cnt != 1) begin
      n_fail++;
      $display("FAIL stretch_after: got %0d pixels %0d errs, required %0d 1", pix_cnt, err_cnt, HA * VA);
    end
  endtask

  task automatic test_wide_de;
    int s;
    s = cyc;
    err_cnt = 0;
    // line 2 carries a 9-pixel DE run; the 9th pixel sits at frame offset 32
    send_frame(NONE, 2, NONE, 2 * HT + HA - 1, ALL);
    n_cmp++;
    if (err_cnt != 1 || err_cyc != s + 2 * HT + HA + 2) begin
      n_fail++;
      $display("FAIL wide_err: got %0d pulses at %0d, required 1 at %0d", err_cnt, err_cyc, s + 2 * HT + HA + 2);
    end
    n_cmp++;
    if (err_x !== 10'(HA - 1) || err_pv !== 1'b0 || err_lk !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_hold: got x=%0d pv=%0b lk=%0b, required x=%0d pv=0 lk=0", err_x, err_pv, err_lk, HA - 1);
    end
    n_cmp++;
    if (locked !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL wide_after: got lk=%0b pending=%0d, required lk=0 pending=0", locked, sb.size());
    end
  endtask

  task automatic test_short_frame_verify;
    int s;
    idle_reset(3);
    s = cyc;
    lock_rise = -1;
    pix_cnt = 0;
    // frame judged at the second vsync loses its last blanking line (6 lines)
    send_frame(NONE, NONE, VT - 1, NONE, ALL);
    send_frame(NONE, NONE, NONE, NONE, ALL);
    send_frame(NONE, NONE, NONE, NONE, ALL);
    n_cmp++;
    if (lock_rise != -1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL short_no_lock: got rise %0d lk=%0b, required none lk=0", lock_rise, locked);
    end
    send_frame(NONE, NONE, NONE, NONE, ALL);
    n_cmp++;
    if (lock_rise != s + (VT - 1) * HT + 2 * VT * HT + VS0 * HT + HS0 + 2) begin
      n_fail++;
      $display("FAIL short_lock_cycle: got %0d, required %0d", lock_rise,
               s + (VT - 1) * HT + 2 * VT * HT + VS0 * HT + HS0 + 2);
    end
    send_frame(NONE, NONE, NONE, ALL, ALL);
    n_cmp++;
    if (pix_cnt != HA * VA || sb.size() != 0) begin
      n_fail++;
      $display("FAIL short_pixels: got %0d pending %0d, required %0d 0", pix_cnt, sb.size(), HA * VA);
    end
  endtask

  task automatic test_async_reset;
    // run into line 1 of a locked frame, stop while hsync is low
    send_frame(NONE, NONE, NONE, ALL, HT + HS0 + 1);
    n_cmp++;
    if (locked !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL areset_pre: got lk=%0b pending=%0d, required lk=1 pending=0", locked, sb.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (locked !== 1'b0 || pixel_valid !== 1'b0 || timing_err !== 1'b0 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_flags: got lk=%0b pv=%0b te=%0b fs=%0b, required 0",
               locked, pixel_valid, timing_err, frame_start);
    end
    n_cmp++;
    if (x_pos !== 10'd0 || y_pos !== 10'd0 || write_addr !== 19'd0) begin
      n_fail++;
      $display("FAIL areset_coords: got x=%0d y=%0d addr=%0d, required 0", x_pos, y_pos, write_addr);
    end
    n_cmp++;
    if (h_total_meas !== 11'd0 || v_total_meas !== 11'd0) begin
      n_fail++;
      $display("FAIL areset_meas: got h=%0d v=%0d, required 0", h_total_meas, v_total_meas);
    end
    @(negedge clk_25mhz);
    cyc++;
    idle_reset(3);
    run_lock_sequence("areset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stretch_line();
    test_wide_de();
    test_short_frame_verify();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
